// File: rtl/zoom_pkg.sv
// Shared types and constants for the vertical zoom stage.
package zoom_pkg;

  localparam int unsigned ZOOM_DATA_W = 8;

  localparam logic ZOOM_MODE_IN  = 1'b1;
  localparam logic ZOOM_MODE_OUT = 1'b0;

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_REPEAT = 2'd1,
    S_DROP   = 2'd2
  } zoom_state_e;

endpackage

// File: rtl/zoom_line_buffer.sv
// Single-line pixel store: synchronous write, asynchronous read.
module zoom_line_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LINE_W = 320,
  parameter int unsigned COL_W  = $clog2(LINE_W)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [COL_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [COL_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [LINE_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/zoom_vertical.sv
// Vertical zoom: repeats each line (zoom in) or drops odd lines (zoom out).
// Optional line_end_out marker enabled by ZOOM_VERTICAL_LINE_END_EN.
module zoom_vertical
  import zoom_pkg::*;
#(
  parameter int unsigned DATA_W = ZOOM_DATA_W,
  parameter int unsigned LINE_W = 320,
  parameter int unsigned COL_W  = $clog2(LINE_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              zoom_in,
  input  logic [DATA_W-1:0] pixel_in,
  input  logic              pixel_valid_in,
  output logic              pixel_ready_out,
  output logic [DATA_W-1:0] pixel_out,
  output logic              pixel_valid_out
`ifdef ZOOM_VERTICAL_LINE_END_EN
  ,
  output logic              line_end_out
`endif
);

  zoom_state_e       state;
  logic [COL_W-1:0]  col;
  logic              mode;
  logic              accept;
  logic              last;
  logic [COL_W-1:0]  col_next;
  logic              buf_we;
  logic [DATA_W-1:0] buf_rdata;

  assign pixel_ready_out = (state != S_REPEAT);
  assign accept          = pixel_valid_in && pixel_ready_out;
  assign last            = (col == COL_W'(LINE_W - 1));
  assign col_next        = last ? '0 : col + COL_W'(1);
  assign buf_we          = accept && (state == S_FILL);

  zoom_line_buffer #(
    .DATA_W (DATA_W),
    .LINE_W (LINE_W),
    .COL_W  (COL_W)
  ) u_line_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (col),
    .wdata (pixel_in),
    .raddr (col),
    .rdata (buf_rdata)
  );

  // Line sequencing; the last-pixel accept and state change share a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_FILL;
      col             <= '0;
      mode            <= ZOOM_MODE_OUT;
      pixel_out       <= '0;
      pixel_valid_out <= 1'b0;
`ifdef ZOOM_VERTICAL_LINE_END_EN
      line_end_out    <= 1'b0;
`endif
    end else begin
      case (state)
        S_FILL: begin
          if (accept) begin
            pixel_out       <= pixel_in;
            pixel_valid_out <= 1'b1;
            col             <= col_next;
`ifdef ZOOM_VERTICAL_LINE_END_EN
            line_end_out    <= last;
`endif
            if (col == '0) mode <= zoom_in;
            if (last) state <= (mode == ZOOM_MODE_IN) ? S_REPEAT : S_DROP;
          end else begin
            pixel_valid_out <= 1'b0;
`ifdef ZOOM_VERTICAL_LINE_END_EN
            line_end_out    <= 1'b0;
`endif
          end
        end
        S_REPEAT: begin
          pixel_out       <= buf_rdata;
          pixel_valid_out <= 1'b1;
          col             <= col_next;
`ifdef ZOOM_VERTICAL_LINE_END_EN
          line_end_out    <= last;
`endif
          if (last) state <= S_FILL;
        end
        S_DROP: begin
          pixel_valid_out <= 1'b0;
`ifdef ZOOM_VERTICAL_LINE_END_EN
          line_end_out    <= 1'b0;
`endif
          if (accept) begin
            col <= col_next;
            if (last) state <= S_FILL;
          end
        end
        default: begin
          state           <= S_FILL;
          col             <= '0;
          pixel_valid_out <= 1'b0;
`ifdef ZOOM_VERTICAL_LINE_END_EN
          line_end_out    <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zoom_vertical.sv
// Directed self-checking bench for zoom_vertical with LINE_W=4.
module tb_zoom_vertical;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned LINE_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              zoom_in;
  logic [DATA_W-1:0] pixel_in;
  logic              pixel_valid_in;
  logic              pixel_ready_out;
  logic [DATA_W-1:0] pixel_out;
  logic              pixel_valid_out;
`ifdef ZOOM_VERTICAL_LINE_END_EN
  logic              line_end_out;
`endif

  zoom_vertical #(
    .DATA_W (DATA_W),
    .LINE_W (LINE_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .zoom_in         (zoom_in),
    .pixel_in        (pixel_in),
    .pixel_valid_in  (pixel_valid_in),
    .pixel_ready_out (pixel_ready_out),
    .pixel_out       (pixel_out),
    .pixel_valid_out (pixel_valid_out)
`ifdef ZOOM_VERTICAL_LINE_END_EN
    ,
    .line_end_out    (line_end_out)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [DATA_W-1:0] out_q[$];
  int                cyc_q[$];
  logic              le_q[$];
  int                not_ready_cnt;
  int                le_stray_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output capture away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (pixel_valid_out) begin
        out_q.push_back(pixel_out);
        cyc_q.push_back(cyc);
`ifdef ZOOM_VERTICAL_LINE_END_EN
        le_q.push_back(line_end_out);
`endif
      end
`ifdef ZOOM_VERTICAL_LINE_END_EN
      if (line_end_out && !pixel_valid_out) le_stray_cnt++;
`endif
      if (!pixel_ready_out) not_ready_cnt++;
    end
  end

  task automatic clear_capture();
    out_q.delete();
    cyc_q.delete();
    le_q.delete();
    not_ready_cnt = 0;
    le_stray_cnt  = 0;
  endtask

  task automatic idle(input int n);
    pixel_valid_in = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one input cycle; a valid pixel is held until accepted.
  task automatic send(input logic [DATA_W-1:0] d, input logic v);
    int n;
    pixel_in       = d;
    pixel_valid_in = v;
    n = 0;
    while (v && !pixel_ready_out && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    pixel_valid_in = 1'b0;
  endtask

  task automatic check_stream(input string tag, input logic [DATA_W-1:0] exp[$]);
    check({tag, "_count"}, 32'(out_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < out_q.size(); i++)
      check($sformatf("%s_pix%0d", tag, i), 32'(out_q[i]), 32'(exp[i]));
  endtask

  task automatic check_spacing(input string tag, input int exp[$]);
    for (int i = 0; i < exp.size() && i < cyc_q.size(); i++)
      check($sformatf("%s_cyc%0d", tag, i), 32'(cyc_q[i] - cyc_q[0]), 32'(exp[i]));
  endtask

  task automatic check_line_end(input string tag, input logic exp[$]);
`ifdef ZOOM_VERTICAL_LINE_END_EN
    for (int i = 0; i < exp.size() && i < le_q.size(); i++)
      check($sformatf("%s_le%0d", tag, i), 32'(le_q[i]), 32'(exp[i]));
    check({tag, "_le_stray"}, 32'(le_stray_cnt), 32'd0);
`else
    if (exp.size() < 0) $display("%s", tag);
`endif
  endtask

  initial begin
    rst            = 1'b1;
    zoom_in        = 1'b1;
    pixel_in       = '0;
    pixel_valid_in = 1'b0;
    clear_capture();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(pixel_valid_out), 32'd0);
    check("reset_pixel", 32'(pixel_out), 32'd0);
    check("reset_ready", 32'(pixel_ready_out), 32'd1);
    rst = 1'b0;
    idle(1);

    // Zoom in, back-to-back input.
    clear_capture();
    zoom_in = 1'b1;
    for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 1'b1);
    idle(8);
    check_stream("zin", '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11, 8'h12, 8'h13});
    check_spacing("zin", '{0, 1, 2, 3, 4, 5, 6, 7});
    check("zin_not_ready", 32'(not_ready_cnt), 32'd4);
    check_line_end("zin", '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});

    // Zoom out: second line dropped, never stalls.
    clear_capture();
    zoom_in = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(8'h20 + i), 1'b1);
    for (int i = 0; i < 4; i++) send(8'(8'h30 + i), 1'b1);
    idle(4);
    check_stream("zout", '{8'h20, 8'h21, 8'h22, 8'h23});
    check("zout_not_ready", 32'(not_ready_cnt), 32'd0);
    check_line_end("zout", '{1'b0, 1'b0, 1'b0, 1'b1});

    // Input bubbles during fill; replay stays gapless.
    clear_capture();
    zoom_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(8'(8'h40 + i), 1'b1);
      if (i < 3) send(8'hEE, 1'b0);
    end
    idle(8);
    check_stream("bub", '{8'h40, 8'h41, 8'h42, 8'h43, 8'h40, 8'h41, 8'h42, 8'h43});
    check_spacing("bub", '{0, 2, 4, 6, 7, 8, 9, 10});

    // zoom_in drops mid-line: line still repeated, following lines use zoom-out.
    clear_capture();
    zoom_in = 1'b1;
    send(8'h50, 1'b1);
    send(8'h51, 1'b1);
    zoom_in = 1'b0;
    send(8'h52, 1'b1);
    send(8'h53, 1'b1);
    for (int i = 0; i < 4; i++) send(8'(8'h60 + i), 1'b1);
    for (int i = 0; i < 4; i++) send(8'(8'h70 + i), 1'b1);
    idle(4);
    check_stream("mode", '{8'h50, 8'h51, 8'h52, 8'h53, 8'h50, 8'h51, 8'h52, 8'h53,
                           8'h60, 8'h61, 8'h62, 8'h63});

    // Asynchronous reset during replay at column 2.
    clear_capture();
    zoom_in = 1'b1;
    for (int i = 0; i < 4; i++) send(8'(8'h80 + i), 1'b1);
    check("arst_in_repeat", 32'(pixel_ready_out), 32'd0);
    idle(2);
    check("arst_pre_valid", 32'(pixel_valid_out), 32'd1);
    check("arst_pre_pixel", 32'(pixel_out), 32'h81);
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(pixel_valid_out), 32'd0);
    check("arst_ready", 32'(pixel_ready_out), 32'd1);
    check("arst_pixel", 32'(pixel_out), 32'd0);
    #2;
    rst = 1'b0;
    idle(1);
    clear_capture();
    for (int i = 0; i < 4; i++) send(8'(8'h90 + i), 1'b1);
    idle(8);
    check_stream("post_rst", '{8'h90, 8'h91, 8'h92, 8'h93, 8'h90, 8'h91, 8'h92, 8'h93});
    check_line_end("post_rst", '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/zoom_vertical.md
Name: zoom_vertical

Overview:
- Stage directly downstream of the horizontal zoom stage; consumes its pixel stream one line at a time.
- Zoom in (zoom_in=1): each input line is emitted twice, so the image doubles vertically.
- Zoom out (zoom_in=0): odd lines (1, 3, 5, …) are dropped, so the image halves vertically.
- Holds one line in an internal line buffer. Output is valid-only (no downstream ready), matching the horizontal stage's output convention.

Parameters:
- DATA_W, 8, pixel width in bits.
- LINE_W, 320, pixels per input line, i.e. the output line width of the horizontal stage. Must be ≥2.
- COL_W, $clog2(LINE_W), width of the column counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pixel_in  in  DATA_W  input pixel.
- pixel_valid_in  in  1  pixel_in is valid this cycle.
- pixel_ready_out  out  1  block can accept a pixel this cycle (combinational from state).
- pixel_out  out  DATA_W  output pixel (registered).
- pixel_valid_out  out  1  pixel_out is valid this cycle (registered).
- zoom_in  in  1  1 = vertical zoom in (line repeat); 0 = zoom out (line drop).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - pixel_out=0, pixel_valid_out=0.
  - state=S_FILL, col=0, mode=0.
  - Line buffer contents are not reset.
- Reset mid-line: the partial line is discarded. The first pixel after reset is column 0 of a new line.
- Handshake: a pixel is accepted when pixel_valid_in && pixel_ready_out. pixel_ready_out=1 in S_FILL and S_DROP, 0 in S_REPEAT.
- Mode latch: mode <= zoom_in on the cycle the column-0 pixel is accepted in S_FILL. Changes to zoom_in mid-line have no effect until the next line start.
- col advances on every accepted pixel (S_FILL/S_DROP) or emitted replay pixel (S_REPEAT). It wraps LINE_W-1 -> 0 and is never compared with ≥LINE_W.
- State machine:
  - S_FILL: on accept, line_buf[col] <= pixel_in, pixel_out <= pixel_in, pixel_valid_out <= 1 (latency 1 cycle). With no accept, pixel_valid_out <= 0. When col=LINE_W-1 is accepted:
    - mode=1 -> S_REPEAT.
    - mode=0 -> S_DROP.
  - S_REPEAT: every cycle, pixel_out <= line_buf[col], pixel_valid_out <= 1. At col=LINE_W-1 -> S_FILL. Occupies exactly LINE_W cycles with input stalled.
  - S_DROP: accepted pixels are discarded and pixel_valid_out <= 0. At accept with col=LINE_W-1 -> S_FILL.
- Simultaneity: the last-pixel accept and the state change happen in the same cycle. The first S_REPEAT output follows immediately, so there are no bubbles between line copies.
- Throughput: the zoom-in output is gapless when the input is gapless. Input bubbles in S_FILL produce output bubbles. S_REPEAT never bubbles.
- Arithmetic: none on pixel data. Widths are preserved, with no truncation or saturation.

Optional Feature:
- Macro: ZOOM_VERTICAL_LINE_END_EN.
- Defined: adds output line_end_out (1 bit, registered, reset 0). It pulses high together with pixel_valid_out on the last pixel (col=LINE_W-1) of every emitted line, in both S_FILL and S_REPEAT. It is never high in S_DROP.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package zoom_pkg:
  - state enum: S_FILL, S_REPEAT, S_DROP as a 2-bit typedef;
  - default DATA_W localparam;
  - mode encodings: ZOOM_MODE_IN=1, ZOOM_MODE_OUT=0.
- Sub-module zoom_line_buffer: LINE_W×DATA_W array, synchronous write with we/waddr/wdata, asynchronous read by raddr. Instantiated once.
- The FSM and counters stay in zoom_vertical.

Test Plan:
- Reset, zoom-in: LINE_W=4, zoom_in=1, reset then feed 0x10,0x11,0x12,0x13 back-to-back -> 8 consecutive valid outputs 0x10..0x13,0x10..0x13; pixel_ready_out low for exactly 4 cycles.
- Zoom-out: zoom_in=0, feed lines A=0x20..0x23 then B=0x30..0x33 -> outputs only 0x20..0x23; no valid during line B; ready stays high throughout.
- Input bubbles: zoom_in=1, valid toggles 1,0,1,0 -> outputs mirror the gaps during fill; replay of 4 pixels is gapless.
- Mode change mid-line: zoom_in goes 1->0 after column 1 of a line -> that line is still repeated; the next line follows zoom-out rules.
- Async reset mid-replay: assert rst during S_REPEAT col=2 -> pixel_valid_out=0 immediately, ready=1, next accepted pixel is column 0.
- With ZOOM_VERTICAL_LINE_END_EN: zoom-in scenario above -> line_end_out high on output 0x13 both times, low otherwise.
